prime_check_ctrl: RTL and testbench

Sequencer that decides whether an unsigned integer is prime by trial division. It drives an external `modulo_is_zero` divisibility unit. Candidate divisors run 2, 3, 5, 7, 9, … while d*d ≤ n. The block returns a prime flag and the smallest factor found. It sits between the request source and the modulo unit inside the prime-checker top level.

---
 rtl/prime_ctrl_pkg.sv | 22 ++
 rtl/prime_check_ctrl_if.sv | 29 ++
 rtl/modulo_is_zero.sv | 68 ++++++
 rtl/prime_check_ctrl.sv | 83 ++++++++
 tb/tb_prime_check_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prime_ctrl_pkg.sv
// Shared types and constants for the trial-division prime checker:
// controller and modulo-unit state encodings, plus the first divisor and its square.
package prime_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    M_IDLE,
    M_BUSY,
    M_RESP
  } mod_state_t;

  localparam int D_FIRST  = 2;
  localparam int SQ_FIRST = 4;

endpackage

// File: rtl/prime_check_ctrl_if.sv
// Bundle of request, result and modulo-unit signals around the prime-check controller.
// Every channel is valid/ready: a transfer happens on a rising edge where both are high,
// and the sender holds valid and its payload stable until that edge.
interface prime_check_ctrl_if #(parameter int WIDTH = 32);
  logic             valid_i;
  logic             ready_i;
  logic [WIDTH-1:0] n_i;
  logic             valid_o;
  logic             ready_o;
  logic             is_prime;
  logic [WIDTH-1:0] factor_o;
  logic             mod_valid;
  logic             mod_ready;
  logic [WIDTH-1:0] mod_a;
  logic [WIDTH-1:0] mod_b;
  logic             mod_y;
  logic             mod_valid_o;
  logic             mod_ready_o;

  modport master (
    input  valid_i, n_i, ready_o, mod_ready, mod_y, mod_valid_o,
    output ready_i, valid_o, is_prime, factor_o, mod_valid, mod_a, mod_b, mod_ready_o
  );

  modport slave (
    output valid_i, n_i, ready_o, mod_ready, mod_y, mod_valid_o,
    input  ready_i, valid_o, is_prime, factor_o, mod_valid, mod_a, mod_b, mod_ready_o
  );
endinterface

// File: rtl/modulo_is_zero.sv
// Divisibility unit: accepts (a, b), runs a bit-serial restoring remainder over WIDTH
// cycles and reports y = (a mod b == 0). Synchronous active-low reset.
module modulo_is_zero
  import prime_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output mod_state_t       state
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_next;

  always_comb begin
    rem_sh   = {rem, a_sh[WIDTH-1]};
    rem_next = WIDTH'(rem_sh);
    if (rem_sh >= (WIDTH + 1)'(b_q)) rem_next = WIDTH'(rem_sh - (WIDTH + 1)'(b_q));
  end

  assign req_ready = (state == M_IDLE);
  assign rsp_valid = (state == M_RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= M_IDLE;
      a_sh  <= '0;
      b_q   <= '0;
      rem   <= '0;
      cnt   <= '0;
      y     <= 1'b0;
    end else begin
      case (state)
        M_IDLE: if (req_valid) begin
          a_sh  <= a;
          b_q   <= b;
          rem   <= '0;
          cnt   <= CW'(WIDTH);
          state <= M_BUSY;
        end
        M_BUSY: begin
          a_sh <= a_sh << 1;
          rem  <= rem_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            y     <= (rem_next == '0);
            state <= M_RESP;
          end
        end
        M_RESP: if (rsp_ready) state <= M_IDLE;
        default: state <= M_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/prime_check_ctrl.sv
// Trial-division sequencer: walks divisors 2,3,5,7,... while d*d <= n, asking the
// external modulo unit about each one, and reports the prime flag and smallest factor.
module prime_check_ctrl
  import prime_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  prime_check_ctrl_if.master bus,
  output state_t             state
);
  localparam int SW = 2 * WIDTH;

  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] d;
  logic [SW-1:0]    sq;
  logic             is_prime_q;
  logic [WIDTH-1:0] factor_q;

  assign bus.ready_i     = (state == IDLE);
  assign bus.valid_o     = (state == DONE);
  assign bus.mod_valid   = (state == ISSUE);
  assign bus.mod_ready_o = (state == WAIT);
  assign bus.mod_a       = n_q;
  assign bus.mod_b       = d;
  assign bus.is_prime    = is_prime_q;
  assign bus.factor_o    = factor_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      n_q        <= '0;
      d          <= '0;
      sq         <= '0;
      is_prime_q <= 1'b0;
      factor_q   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.valid_i) begin
          n_q <= bus.n_i;
          d   <= WIDTH'(D_FIRST);
          sq  <= SW'(SQ_FIRST);
          if (bus.n_i < WIDTH'(2)) begin
            is_prime_q <= 1'b0;
            factor_q   <= '0;
            state      <= DONE;
          end else begin
            state <= CHECK;
          end
        end
        // sq is double width, so d*d is compared exactly against n.
        CHECK: if (sq > SW'(n_q)) begin
          is_prime_q <= 1'b1;
          factor_q   <= '0;
          state      <= DONE;
        end else begin
          state <= ISSUE;
        end
        ISSUE: if (bus.mod_ready) state <= WAIT;
        WAIT: if (bus.mod_valid_o) begin
          if (bus.mod_y) begin
            is_prime_q <= 1'b0;
            factor_q   <= d;
            state      <= DONE;
          end else begin
            // (d+2)^2 = d^2 + 4d + 4 keeps the square current without a multiplier.
            if (d == WIDTH'(D_FIRST)) begin
              d  <= WIDTH'(3);
              sq <= SW'(9);
            end else begin
              d  <= d + WIDTH'(2);
              sq <= sq + (SW'(d) << 2) + SW'(4);
            end
            state <= CHECK;
          end
        end
        DONE: if (bus.ready_o) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prime_check_ctrl.sv
// Bench for prime_check_ctrl with a real modulo_is_zero beside it (WIDTH=16):
// directed corner cases, backpressure, mid-run reset and random candidates.
module tb_prime_check_ctrl;
  import prime_ctrl_pkg::*;

  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hold = 1'b0;
  bit         rand_bp = 1'b0;
  state_t     state;
  mod_state_t mod_state;
  logic       unit_req_ready;

  int total = 0;
  int bad = 0;

  logic [W-1:0] exp_q[$];
  bit           exp_prime_q[$];
  int           exp_hs_q[$];
  logic [W-1:0] exp_div_q[$];
  logic [W-1:0] cur_n = '0;
  int           hs_cnt = 0;
  bit           stall_prev = 1'b0;
  logic [W-1:0] stall_a, stall_b;

  prime_check_ctrl_if #(.WIDTH(W)) bus ();

  assign bus.mod_ready = unit_req_ready & ~hold;

  prime_check_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master),
    .state (state)
  );

  modulo_is_zero #(.WIDTH(W)) u_mod (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (bus.mod_valid & ~hold),
    .req_ready (unit_req_ready),
    .a         (bus.mod_a),
    .b         (bus.mod_b),
    .y         (bus.mod_y),
    .rsp_valid (bus.mod_valid_o),
    .rsp_ready (bus.mod_ready_o),
    .state     (mod_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Reference: plain trial division, listing the divisors the DUT must ask about.
  task automatic model(input int n, output bit prime, output int factor, output int hs,
                       input bit push_div);
    int d;
    prime = 1'b0;
    factor = 0;
    hs = 0;
    if (n < 2) return;
    d = 2;
    while (d * d <= n) begin
      hs++;
      if (push_div) exp_div_q.push_back(W'(d));
      if (n % d == 0) begin
        factor = d;
        return;
      end
      d = (d == 2) ? 3 : d + 2;
    end
    prime = 1'b1;
  endtask

  task automatic send(input int n);
    bit p;
    int f, h;
    int g = 0;
    while (bus.ready_i !== 1'b1 && g < 6000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 6000) fail_now("send_wait_ready");
    model(n, p, f, h, 1'b1);
    exp_prime_q.push_back(p);
    exp_q.push_back(W'(f));
    exp_hs_q.push_back(h);
    bus.valid_i = 1'b1;
    bus.n_i = W'(n);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    if (n < 2) begin
      check("short_valid_o_latency", 32'(bus.valid_o), 32'd1);
    end else begin
      check("accept_to_check", 32'(state), 32'(CHECK));
      check("no_early_mod_valid", 32'(bus.mod_valid), 32'd0);
    end
  endtask

  task automatic wait_done();
    int g = 0;
    while ((exp_q.size() != 0 || state != IDLE) && g < 6000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 6000) fail_now("wait_done");
  endtask

  task automatic wait_state(input state_t s, input string name);
    int g = 0;
    while (state != s && g < 6000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 6000) fail_now(name);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},       32'(state), 32'(IDLE));
    check({tag, "_ready_i"},     32'(bus.ready_i), 32'd1);
    check({tag, "_valid_o"},     32'(bus.valid_o), 32'd0);
    check({tag, "_is_prime"},    32'(bus.is_prime), 32'd0);
    check({tag, "_factor_o"},    32'(bus.factor_o), 32'd0);
    check({tag, "_mod_valid"},   32'(bus.mod_valid), 32'd0);
    check({tag, "_mod_a"},       32'(bus.mod_a), 32'd0);
    check({tag, "_mod_b"},       32'(bus.mod_b), 32'd0);
    check({tag, "_mod_ready_o"}, 32'(bus.mod_ready_o), 32'd0);
  endtask

  // Compare process: divisor sequence, stall stability and every consumed result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid_i && bus.ready_i) begin
        cur_n = bus.n_i;
        hs_cnt = 0;
      end
      if (bus.mod_valid && !bus.mod_ready) begin
        if (stall_prev) begin
          check("stall_mod_a", 32'(bus.mod_a), 32'(stall_a));
          check("stall_mod_b", 32'(bus.mod_b), 32'(stall_b));
        end
        stall_prev = 1'b1;
        stall_a = bus.mod_a;
        stall_b = bus.mod_b;
      end else begin
        stall_prev = 1'b0;
      end
      if (bus.mod_valid && bus.mod_ready) begin
        hs_cnt++;
        check("mod_a", 32'(bus.mod_a), 32'(cur_n));
        if (exp_div_q.size() == 0) fail_now("extra_mod_request");
        else check("mod_b", 32'(bus.mod_b), 32'(exp_div_q.pop_front()));
      end
      if (bus.valid_o && bus.ready_o) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          check("is_prime", 32'(bus.is_prime), 32'(exp_prime_q.pop_front()));
          check("factor_o", 32'(bus.factor_o), 32'(exp_q.pop_front()));
          check("mod_handshakes", 32'(hs_cnt), 32'(exp_hs_q.pop_front()));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_bp) begin
        hold = ($urandom_range(0, 3) == 0);
        bus.ready_o = ($urandom_range(0, 2) != 0);
      end
    end
  end

  initial begin
    bit p;
    int f, h;
    logic [W-1:0] a0, b0, f0;
    logic ip0;

    bus.valid_i = 1'b0;
    bus.n_i = '0;
    bus.ready_o = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    model(91, p, f, h, 1'b0);
    check("model_91_factor", 32'(f), 32'd7);
    model(25, p, f, h, 1'b0);
    check("model_25_hs", 32'(h), 32'd3);
    model(97, p, f, h, 1'b0);
    check("model_97_hs", 32'(h), 32'd5);
    check("model_97_prime", 32'(p), 32'd1);
    model(65521, p, f, h, 1'b0);
    check("model_65521_hs", 32'(h), 32'd128);

    foreach (exp_prime_q[i]) exp_prime_q.delete();
    send(0);     wait_done();
    send(1);     wait_done();
    send(2);     wait_done();
    send(3);     wait_done();
    send(4);     wait_done();
    send(25);    wait_done();
    send(91);    wait_done();
    send(97);    wait_done();
    send(65521); wait_done();
    check("prime_65521_flag", 32'(bus.is_prime), 32'd1);

    // Modulo unit stalled for 5 cycles.
    hold = 1'b1;
    send(91);
    wait_state(ISSUE, "wait_issue");
    a0 = bus.mod_a;
    b0 = bus.mod_b;
    check("hold_first_b", 32'(b0), 32'd2);
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_state", 32'(state), 32'(ISSUE));
      check("hold_a", 32'(bus.mod_a), 32'(a0));
      check("hold_b", 32'(bus.mod_b), 32'(b0));
    end
    hold = 1'b0;
    wait_done();

    // Result consumer stalled for 10 cycles while a new request is offered.
    bus.ready_o = 1'b0;
    send(97);
    wait_state(DONE, "wait_done_state");
    ip0 = bus.is_prime;
    f0 = bus.factor_o;
    bus.valid_i = 1'b1;
    bus.n_i = W'(13);
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_valid_o", 32'(bus.valid_o), 32'd1);
      check("bp_ready_i", 32'(bus.ready_i), 32'd0);
      check("bp_is_prime", 32'(bus.is_prime), 32'(ip0));
      check("bp_factor", 32'(bus.factor_o), 32'(f0));
    end
    bus.valid_i = 1'b0;
    bus.ready_o = 1'b1;
    wait_done();

    // Reset while waiting on the modulo unit.
    send(65521);
    wait_state(WAIT, "wait_wait");
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    exp_prime_q.delete();
    exp_hs_q.delete();
    exp_div_q.delete();
    hs_cnt = 0;
    stall_prev = 1'b0;
    @(posedge clk); #1;
    check("midrst_mod_unit", 32'(mod_state), 32'(M_IDLE));
    rst_n = 1'b1;
    send(9);
    wait_done();

    // Random candidates under random backpressure on both sides.
    rand_bp = 1'b1;
    repeat (25) begin
      send(int'($urandom_range(0, 4095)));
    end
    wait_done();
    rand_bp = 1'b0;
    hold = 1'b0;
    bus.ready_o = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
